// File: rtl/redmule_pkg.sv
// Shared types and helpers for the RedMulE streamer source blocks.
package redmule_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } lin_src_state_e;

    typedef struct packed {
        logic ready_start;
        logic done;
    } lin_src_flags_t;

    // A zero-length dimension behaves like a single-beat dimension.
    function automatic logic [31:0] len_or_one(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/redmule_lin_src_fifo.sv
// Response buffer for the linear stream source; registered head, no fall-through.
module redmule_lin_src_fifo #(
    parameter int unsigned DW    = 512,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    // Storage is not reset, so an empty buffer presents zero instead of stale data.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/redmule_lin_stream_source.sv
// Streamer source: walks a 3-D address pattern, issues reads, returns data in order.
// IDLE wait for start | RUN issue reads | DRAIN flush buffered beats | DONE one-cycle done pulse
module redmule_lin_stream_source
    import redmule_pkg::*;
#(
    parameter int unsigned DW         = 512,
    parameter int unsigned AW         = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          req_start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [31:0]   tot_len_i,
    input  logic [31:0]   d0_len_i,
    input  logic [31:0]   d0_stride_i,
    input  logic [31:0]   d1_len_i,
    input  logic [31:0]   d1_stride_i,
    input  logic [31:0]   d2_stride_i,
    input  logic [1:0]    dim_en_i,
    output logic          ready_start_o,
    output logic          done_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_add_o,
    input  logic          mem_gnt_i,
    input  logic          mem_r_valid_i,
    input  logic [DW-1:0] mem_r_data_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    lin_src_state_e state_q, state_d;
    lin_src_flags_t flags;

    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] d0_stride_q, d0_stride_d, d1_stride_q, d1_stride_d, d2_stride_q, d2_stride_d;
    logic [AW-1:0] d0_acc_q, d0_acc_d, d1_acc_q, d1_acc_d, d2_acc_q, d2_acc_d;
    logic [31:0]   tot_len_q, tot_len_d, d0_len_q, d0_len_d, d1_len_q, d1_len_d;
    logic [31:0]   d0_cnt_q, d0_cnt_d, d1_cnt_q, d1_cnt_d, beat_cnt_q, beat_cnt_d;
    logic [1:0]    dim_en_q, dim_en_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          drop_q;

    logic          grant, resp_ok, resp_push, pop, credit_ok;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count, fifo_count_nxt;
    logic [CW:0]   in_flight;

    // Every outstanding read owns a buffer slot, so responses never need stalling.
    assign in_flight = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok = !fifo_full && (in_flight < (CW+1)'(FIFO_DEPTH));
    assign mem_req_o = (state_q == RUN) && credit_ok;
    assign mem_add_o = base_q + d0_acc_q + d1_acc_q + d2_acc_q;
    assign grant     = mem_req_o && mem_gnt_i;

    // The response to a read granted around a clear belongs to the aborted job.
    assign resp_ok   = mem_r_valid_i && !drop_q;
    assign resp_push = resp_ok && !clear_i;
    assign valid_o   = !fifo_empty;
    assign pop       = valid_o && ready_i;
    assign fifo_count_nxt = fifo_count + CW'(resp_push) - CW'(pop);

    assign flags         = '{ready_start: (state_q == IDLE), done: (state_q == DONE)};
    assign ready_start_o = flags.ready_start;
    assign done_o        = flags.done;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        tot_len_d   = tot_len_q;
        d0_len_d    = d0_len_q;
        d1_len_d    = d1_len_q;
        d0_stride_d = d0_stride_q;
        d1_stride_d = d1_stride_q;
        d2_stride_d = d2_stride_q;
        dim_en_d    = dim_en_q;
        d0_cnt_d    = d0_cnt_q;
        d1_cnt_d    = d1_cnt_q;
        d0_acc_d    = d0_acc_q;
        d1_acc_d    = d1_acc_q;
        d2_acc_d    = d2_acc_q;
        beat_cnt_d  = beat_cnt_q;
        outst_d     = outst_q + CW'(grant) - CW'(resp_ok);

        case (state_q)
            IDLE: begin
                if (req_start_i) begin
                    base_d      = base_addr_i;
                    tot_len_d   = tot_len_i;
                    d0_len_d    = len_or_one(d0_len_i);
                    d1_len_d    = len_or_one(d1_len_i);
                    d0_stride_d = AW'(d0_stride_i);
                    d1_stride_d = AW'(d1_stride_i);
                    d2_stride_d = AW'(d2_stride_i);
                    dim_en_d    = dim_en_i;
                    d0_cnt_d    = '0;
                    d1_cnt_d    = '0;
                    d0_acc_d    = '0;
                    d1_acc_d    = '0;
                    d2_acc_d    = '0;
                    beat_cnt_d  = '0;
                    state_d     = (tot_len_i == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (grant) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (beat_cnt_d == tot_len_q) state_d = DRAIN;
                    if (d0_cnt_q == d0_len_q - 32'd1) begin
                        d0_cnt_d = '0;
                        d0_acc_d = '0;
                        if (dim_en_q[0]) begin
                            if (d1_cnt_q == d1_len_q - 32'd1) begin
                                d1_cnt_d = '0;
                                d1_acc_d = '0;
                                if (dim_en_q[1]) d2_acc_d = d2_acc_q + d2_stride_q;
                            end else begin
                                d1_cnt_d = d1_cnt_q + 32'd1;
                                d1_acc_d = d1_acc_q + d1_stride_q;
                            end
                        end
                    end else begin
                        d0_cnt_d = d0_cnt_q + 32'd1;
                        d0_acc_d = d0_acc_q + d0_stride_q;
                    end
                end
            end
            // Look at next-cycle occupancy so done lands one cycle after the last handshake.
            DRAIN: if (outst_d == '0 && fifo_count_nxt == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d     = IDLE;
            base_d      = '0;
            tot_len_d   = '0;
            d0_len_d    = '0;
            d1_len_d    = '0;
            d0_stride_d = '0;
            d1_stride_d = '0;
            d2_stride_d = '0;
            dim_en_d    = '0;
            d0_cnt_d    = '0;
            d1_cnt_d    = '0;
            d0_acc_d    = '0;
            d1_acc_d    = '0;
            d2_acc_d    = '0;
            beat_cnt_d  = '0;
            outst_d     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            tot_len_q   <= '0;
            d0_len_q    <= '0;
            d1_len_q    <= '0;
            d0_stride_q <= '0;
            d1_stride_q <= '0;
            d2_stride_q <= '0;
            dim_en_q    <= '0;
            d0_cnt_q    <= '0;
            d1_cnt_q    <= '0;
            d0_acc_q    <= '0;
            d1_acc_q    <= '0;
            d2_acc_q    <= '0;
            beat_cnt_q  <= '0;
            outst_q     <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            tot_len_q   <= tot_len_d;
            d0_len_q    <= d0_len_d;
            d1_len_q    <= d1_len_d;
            d0_stride_q <= d0_stride_d;
            d1_stride_q <= d1_stride_d;
            d2_stride_q <= d2_stride_d;
            dim_en_q    <= dim_en_d;
            d0_cnt_q    <= d0_cnt_d;
            d1_cnt_q    <= d1_cnt_d;
            d0_acc_q    <= d0_acc_d;
            d1_acc_q    <= d1_acc_d;
            d2_acc_q    <= d2_acc_d;
            beat_cnt_q  <= beat_cnt_d;
            outst_q     <= outst_d;
            drop_q      <= clear_i;
        end
    end

    redmule_lin_src_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (resp_push),
        .data_i  (mem_r_data_i),
        .pop_i   (pop),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_redmule_lin_stream_source.sv
// Scoreboard bench for redmule_lin_stream_source with a one-cycle-latency memory responder.
module tb_redmule_lin_stream_source;

    localparam int DW = 512;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i, clear_i, req_start_i;
    logic [AW-1:0] base_addr_i;
    logic [31:0]   tot_len_i, d0_len_i, d0_stride_i, d1_len_i, d1_stride_i, d2_stride_i;
    logic [1:0]    dim_en_i;
    logic          ready_start_o, done_o, mem_req_o;
    logic [AW-1:0] mem_add_o;
    logic          mem_gnt_i, mem_r_valid_i;
    logic [DW-1:0] mem_r_data_i, data_o;
    logic          valid_o, ready_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_hs_cyc = -100;
    int grant_cnt = 0;
    int stall_idx = -1;
    int stall_left = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;

    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];

    redmule_lin_stream_source #(.DW(DW), .AW(AW), .FIFO_DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .req_start_i   (req_start_i),
        .base_addr_i   (base_addr_i),
        .tot_len_i     (tot_len_i),
        .d0_len_i      (d0_len_i),
        .d0_stride_i   (d0_stride_i),
        .d1_len_i      (d1_len_i),
        .d1_stride_i   (d1_stride_i),
        .d2_stride_i   (d2_stride_i),
        .dim_en_i      (dim_en_i),
        .ready_start_o (ready_start_o),
        .done_o        (done_o),
        .mem_req_o     (mem_req_o),
        .mem_add_o     (mem_add_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_r_valid_i (mem_r_valid_i),
        .mem_r_data_i  (mem_r_data_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] beat_of(input logic [AW-1:0] a);
        return {16{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [AW-1:0] a);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(beat_of(a));
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Memory: answers every grant exactly one cycle later; can hold gnt low on a chosen request.
    initial begin
        mem_gnt_i = 1'b1;
        mem_r_valid_i = 1'b0;
        mem_r_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_r_valid_i = pend;
            mem_r_data_i  = pend ? beat_of(pend_addr) : '0;
            if (stall_left > 0 && mem_req_o && grant_cnt == stall_idx) begin
                mem_gnt_i = 1'b0;
                stall_left--;
            end else begin
                mem_gnt_i = 1'b1;
            end
        end
    end

    // Request monitor: every presented address must match the scoreboard head.
    initial forever begin
        @(negedge clk_i);
        pend      = mem_req_o && mem_gnt_i;
        pend_addr = mem_add_o;
        if (mem_req_o) begin
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got addr %0h, no request expected", mem_add_o);
            end else begin
                chk("req_addr", mem_add_o, exp_addr_q[0]);
                if (mem_gnt_i) void'(exp_addr_q.pop_front());
            end
            if (mem_gnt_i) grant_cnt++;
        end
    end

    // Output monitor: every handshake must match the next expected beat.
    initial forever begin
        @(negedge clk_i);
        if (valid_o && ready_i) begin
            last_hs_cyc = cyc;
            if (exp_data_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got %0h, no beat expected", data_o[31:0]);
            end else begin
                chk("beat_data", data_o, exp_data_q.pop_front());
            end
        end
    end

    task automatic do_start(input logic [31:0] base, input logic [31:0] tot,
                            input logic [31:0] d0l, input logic [31:0] d0s,
                            input logic [31:0] d1l, input logic [31:0] d1s,
                            input logic [31:0] d2s, input logic [1:0] en);
        @(posedge clk_i);
        #1;
        base_addr_i = base; tot_len_i = tot; d0_len_i = d0l; d0_stride_i = d0s;
        d1_len_i = d1l; d1_stride_i = d1s; d2_stride_i = d2s; dim_en_i = en;
        req_start_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_start_i = 1'b0;
        // Junk parameters afterwards: only the start-cycle values may matter.
        base_addr_i = 32'hDEAD_BEE0; tot_len_i = 32'd99; d0_len_i = 32'd7; d0_stride_i = 32'h30;
        d1_len_i = 32'd5; d1_stride_i = 32'h700; d2_stride_i = 32'h9000; dim_en_i = 2'b11;
    endtask

    task automatic wait_done(input int bound, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done_o within %0d cycles", name, bound);
        end else begin
            chk({name, "_done_latency"}, DW'(cyc - last_hs_cyc), DW'(1));
        end
        @(negedge clk_i);
        chk({name, "_done_pulse"}, DW'(done_o), DW'(0));
        chk({name, "_ready_start"}, DW'(ready_start_o), DW'(1));
        chk({name, "_beats_left"}, DW'(exp_data_q.size()), DW'(0));
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; req_start_i = 1'b0; ready_i = 1'b1;
        base_addr_i = '0; tot_len_i = '0; d0_len_i = '0; d0_stride_i = '0;
        d1_len_i = '0; d1_stride_i = '0; d2_stride_i = '0; dim_en_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready_start", DW'(ready_start_o), DW'(1));
        chk("rst_done", DW'(done_o), DW'(0));
        chk("rst_req", DW'(mem_req_o), DW'(0));
        chk("rst_addr", DW'(mem_add_o), DW'(0));
        chk("rst_valid", DW'(valid_o), DW'(0));
        chk("rst_data", data_o, '0);

        // Linear read along d1.
        expect_beat(32'h100); expect_beat(32'h140); expect_beat(32'h180); expect_beat(32'h1C0);
        do_start(32'h100, 4, 1, 0, 4, 64, 0, 2'b01);
        chk("lin_first_req", DW'(mem_req_o), DW'(1));
        chk("lin_busy", DW'(ready_start_o), DW'(0));
        wait_done(50, "lin");

        // 3-D wrap.
        expect_beat(32'h000); expect_beat(32'h004); expect_beat(32'h040); expect_beat(32'h044);
        expect_beat(32'h200); expect_beat(32'h204); expect_beat(32'h240); expect_beat(32'h244);
        do_start(32'h0, 8, 2, 4, 2, 32'h40, 32'h200, 2'b11);
        wait_done(60, "wrap");

        // Backpressure: only FIFO_DEPTH reads may be issued while the output is blocked.
        begin
            int g0;
            ready_i = 1'b0;
            expect_beat(32'h1000); expect_beat(32'h1004); expect_beat(32'h1008); expect_beat(32'h100C);
            expect_beat(32'h1010); expect_beat(32'h1014); expect_beat(32'h1018); expect_beat(32'h101C);
            g0 = grant_cnt;
            do_start(32'h1000, 8, 8, 4, 1, 0, 0, 2'b00);
            repeat (20) @(posedge clk_i);
            #1;
            chk("bp_grants", DW'(grant_cnt - g0), DW'(4));
            chk("bp_req_low", DW'(mem_req_o), DW'(0));
            chk("bp_valid", DW'(valid_o), DW'(1));
            ready_i = 1'b1;
            wait_done(100, "bp");
        end

        // Grant stall on the second request.
        expect_beat(32'h2000); expect_beat(32'h2008); expect_beat(32'h2010); expect_beat(32'h2018);
        stall_idx = grant_cnt + 1;
        stall_left = 3;
        do_start(32'h2000, 4, 4, 8, 1, 0, 0, 2'b00);
        wait_done(60, "stall");
        chk("stall_consumed", DW'(stall_left), DW'(0));

        // Zero-length job.
        do_start(32'h3000, 0, 1, 0, 1, 0, 0, 2'b00);
        chk("zero_done", DW'(done_o), DW'(1));
        chk("zero_req", DW'(mem_req_o), DW'(0));
        @(posedge clk_i);
        #1;
        chk("zero_done_pulse", DW'(done_o), DW'(0));
        chk("zero_ready_start", DW'(ready_start_o), DW'(1));

        // Clear after two grants, then a fresh job.
        begin
            int g0;
            ready_i = 1'b0;
            for (int i = 0; i < 8; i++) expect_beat(32'h4000 + 32'(4 * i));
            g0 = grant_cnt;
            do_start(32'h4000, 8, 8, 4, 1, 0, 0, 2'b00);
            for (int i = 0; i < 20; i++) begin
                @(posedge clk_i);
                #1;
                if (grant_cnt >= g0 + 2) break;
            end
            chk("clr_two_grants", DW'(grant_cnt - g0), DW'(2));
            clear_i = 1'b1;
            @(posedge clk_i);
            #1;
            clear_i = 1'b0;
            exp_addr_q.delete();
            exp_data_q.delete();
            chk("clr_idle", DW'(ready_start_o), DW'(1));
            chk("clr_req", DW'(mem_req_o), DW'(0));
            chk("clr_valid", DW'(valid_o), DW'(0));
            ready_i = 1'b1;
            repeat (2) begin
                @(posedge clk_i);
                #1;
                chk("clr_late_resp", DW'(valid_o), DW'(0));
            end
            expect_beat(32'h800); expect_beat(32'h810); expect_beat(32'h820);
            do_start(32'h800, 3, 3, 32'h10, 1, 0, 0, 2'b00);
            wait_done(50, "after_clr");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
